// File: rtl/led_module.sv
// Memory-mapped LED output peripheral: static levels, per-LED blinking and
// shared fixed-length one-shot flashes, with registered pins and read-back.
module led_module #(
    parameter int unsigned NUM_LEDS       = 6,
    parameter int unsigned PULSE_CYCLES   = 2700000,
    parameter int unsigned DEFAULT_PERIOD = 13500000,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wen,
    input  logic                ren,
    input  logic [31:0]         address,
    input  logic [31:0]         data_in,
    output logic [31:0]         data_out,
    output logic [NUM_LEDS-1:0] led
);

    localparam int unsigned PER_W  = 24;
    localparam int unsigned PCNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    logic [NUM_LEDS-1:0] r_value;
    logic [NUM_LEDS-1:0] r_mask;
    logic [PER_W-1:0]    r_period;
    logic [PER_W-1:0]    r_blink_cnt;
    logic                r_phase;
    logic [NUM_LEDS-1:0] r_pulse_active;
    logic [PCNT_W-1:0]   r_pulse_cnt;

    logic                w_wr_value;
    logic                w_wr_mask;
    logic                w_wr_period;
    logic                w_wr_pulse;
    logic [NUM_LEDS-1:0] w_on;
    logic [31:0]         w_rd_data;
    logic                w_unused;

    // Bits outside the decoded address and store-data fields
    assign w_unused = ^{address[31:4], address[1:0], data_in[31:24]};

    assign w_wr_value  = wen && (address[3:2] == 2'd0);
    assign w_wr_mask   = wen && (address[3:2] == 2'd1);
    assign w_wr_period = wen && (address[3:2] == 2'd2);
    assign w_wr_pulse  = wen && (address[3:2] == 2'd3);

    // Control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value  <= '0;
            r_mask   <= '0;
            r_period <= PER_W'(DEFAULT_PERIOD);
        end else begin
            if (w_wr_value) begin
                r_value <= data_in[NUM_LEDS-1:0];
            end
            if (w_wr_mask) begin
                r_mask <= data_in[NUM_LEDS-1:0];
            end
            if (w_wr_period) begin
                r_period <= data_in[PER_W-1:0];
            end
        end
    end

    // Blink engine: phase toggles every r_period cycles; period 0 parks it dark
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_wr_period || (r_period == '0)) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == (r_period - PER_W'(1))) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + PER_W'(1);
        end
    end

    // Pulse engine: one shared countdown, new bits join a running flash
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pulse_active <= '0;
            r_pulse_cnt    <= '0;
        end else if (w_wr_pulse) begin
            r_pulse_active <= r_pulse_active | data_in[NUM_LEDS-1:0];
            r_pulse_cnt    <= PCNT_W'(PULSE_CYCLES - 1);
        end else if (r_pulse_active != '0) begin
            if (r_pulse_cnt == '0) begin
                r_pulse_active <= '0;
            end else begin
                r_pulse_cnt <= r_pulse_cnt - PCNT_W'(1);
            end
        end
    end

    always_comb begin
        w_on = (r_value & ~r_mask)
             | (r_value & r_mask & {NUM_LEDS{r_phase}})
             | r_pulse_active;
    end

    always_comb begin
        w_rd_data = '0;
        case (address[3:2])
            2'd0:    w_rd_data = 32'(r_value);
            2'd1:    w_rd_data = 32'(r_mask);
            2'd2:    w_rd_data = 32'(r_period);
            default: w_rd_data = 32'(r_pulse_active);
        endcase
    end

    // Registered pins and read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led      <= ACTIVE_LOW ? '1 : '0;
            data_out <= '0;
        end else begin
            led <= ACTIVE_LOW ? ~w_on : w_on;
            if (ren) begin
                data_out <= w_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_led_module.sv
// Scoreboarded random + directed bench for led_module against a
// time-based reference model (elapsed cycles, flash deadlines).
module tb_led_module;

    localparam int unsigned NL  = 6;
    localparam int unsigned PC  = 8;
    localparam int unsigned DP  = 5;

    logic          clk;
    logic          rst_n;
    logic          wen;
    logic          ren;
    logic [31:0]   address;
    logic [31:0]   data_in;
    logic [31:0]   data_out;
    logic [NL-1:0] led;

    led_module #(
        .NUM_LEDS      (NL),
        .PULSE_CYCLES  (PC),
        .DEFAULT_PERIOD(DP),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wen     (wen),
        .ren     (ren),
        .address (address),
        .data_in (data_in),
        .data_out(data_out),
        .led     (led)
    );

    typedef struct packed {
        logic [NL-1:0] led;
        logic [31:0]   dout;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [NL-1:0] m_value, m_mask, m_pulse;
    logic [23:0]   m_period;
    longint        m_t;       // cycles since last period write / reset
    longint        m_cyc;     // edge index
    longint        m_end;     // edge at which the flash expires
    logic [31:0]   m_dout;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_phase();
        if (m_period == 24'd0) return 1'b0;
        return ((m_t / longint'(m_period)) % 2) == 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] sel);
        case (sel)
            2'd0:    return {26'd0, m_value};
            2'd1:    return {26'd0, m_mask};
            2'd2:    return {8'd0, m_period};
            default: return {26'd0, m_pulse};
        endcase
    endfunction

    task automatic step(input logic rn, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d);
        exp_t          e;
        logic [NL-1:0] on;
        bit            ph;
        @(negedge clk);
        rst_n = rn; wen = w; ren = r; address = a; data_in = d;
        ph = m_phase();
        for (int i = 0; i < NL; i++) begin
            on[i] = (m_value[i] && (!m_mask[i] || ph)) || m_pulse[i];
        end
        m_cyc++;
        if (!rn) begin
            e.led    = '1;
            m_dout   = '0;
            m_value  = '0;
            m_mask   = '0;
            m_period = 24'(DP);
            m_pulse  = '0;
            m_t      = 0;
            m_end    = 0;
        end else begin
            e.led = ~on;
            if (r) m_dout = m_read(a[3:2]);
            m_t++;
            if (w && a[3:2] == 2'd0) m_value = d[NL-1:0];
            if (w && a[3:2] == 2'd1) m_mask  = d[NL-1:0];
            if (w && a[3:2] == 2'd2) begin
                m_period = d[23:0];
                m_t      = 0;
            end
            if (w && a[3:2] == 2'd3) begin
                m_pulse = m_pulse | d[NL-1:0];
                m_end   = m_cyc + PC;
            end else if (m_cyc >= m_end) begin
                m_pulse = '0;
            end
        end
        e.dout = m_dout;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b0, 1'b1, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Monitor: every edge the DUT presents led/data_out, compare to the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (led !== e.led) begin
                    errors++;
                    $display("FAIL led: got %b expected %b at %0t", led, e.led, $time);
                end
                checks++;
                if (data_out !== e.dout) begin
                    errors++;
                    $display("FAIL data_out: got %h expected %h at %0t", data_out, e.dout, $time);
                end
            end
        end
    end

    initial begin
        logic [31:0] a, d;
        logic        rn, w, r;
        rst_n = 1'b0; wen = 1'b0; ren = 1'b0; address = '0; data_in = '0;
        m_value = '0; m_mask = '0; m_pulse = '0; m_period = 24'(DP);
        m_t = 0; m_cyc = 0; m_end = 0; m_dout = '0;

        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        wr(32'h0, 32'h15); idle(2); rd(32'h0); idle(1);

        wr(32'h4, 32'h1); wr(32'h0, 32'h1); wr(32'h8, 32'h4); idle(20);
        wr(32'h8, 32'h0); idle(10);

        wr(32'h0, 32'h0); wr(32'h4, 32'h0); wr(32'hC, 32'h20); idle(3);
        rd(32'hC); idle(8); rd(32'hC); idle(1);

        wr(32'hC, 32'h1); idle(4); wr(32'hC, 32'h2); idle(12);
        wr(32'hC, 32'h0); idle(10);

        step(1'b1, 1'b1, 1'b1, 32'h4, 32'h3F); rd(32'h4); idle(1);

        wr(32'h0, 32'h3F); wr(32'hC, 32'h1); idle(3);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h15);
        rd(32'hC); rd(32'h0); idle(2);

        // Randomised traffic with undecoded address/data bits scrambled
        for (int n = 0; n < 3000; n++) begin
            a = $urandom();
            d = $urandom();
            a[3:2] = 2'($urandom_range(0, 3));
            if (a[3:2] == 2'd2) d = d & 32'hFF00_0007;
            rn = ($urandom_range(0, 199) != 0);
            w  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 1) == 1);
            if (w && a[3:2] == 2'd3 && $urandom_range(0, 3) != 0) w = 1'b0;
            step(rn, w, r, a, d);
        end
        idle(4);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
